alu_mc: RTL and testbench

- Parametrised, registered, multi-cycle ALU. Next generation of the team's bitwise-op, LUI and compare primitives.
- Adds arithmetic with flags and iterative shifts (one bit per cycle).
- Uses valid/ready handshakes on input and output.
- Sits between the register-file read stage and the writeback bus in the datapath.

---
 rtl/alu_mc_pkg.sv | 31 +++
 rtl/alu_mc_comb.sv | 58 +++++
 rtl/alu_mc.sv | 147 ++++++++++++++
 tb/tb_alu_mc.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_mc_pkg.sv
// Shared opcodes, FSM state encoding and helpers for the multi-cycle ALU.
package alu_mc_pkg;

    localparam logic [3:0] OP_OR    = 4'd0;
    localparam logic [3:0] OP_AND   = 4'd1;
    localparam logic [3:0] OP_XOR   = 4'd2;
    localparam logic [3:0] OP_NOR   = 4'd3;
    localparam logic [3:0] OP_NOT_A = 4'd4;
    localparam logic [3:0] OP_PASS_A = 4'd5;
    localparam logic [3:0] OP_PASS_B = 4'd6;
    localparam logic [3:0] OP_LUI   = 4'd7;
    localparam logic [3:0] OP_ADD   = 4'd8;
    localparam logic [3:0] OP_SUB   = 4'd9;
    localparam logic [3:0] OP_SLT   = 4'd10;
    localparam logic [3:0] OP_SGT   = 4'd11;
    localparam logic [3:0] OP_SLL   = 4'd12;
    localparam logic [3:0] OP_SRL   = 4'd13;
    localparam logic [3:0] OP_SRA   = 4'd14;
    localparam logic [3:0] OP_RSVD  = 4'd15;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    function automatic logic is_shift(input logic [3:0] op);
        return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
    endfunction

endpackage

// File: rtl/alu_mc_comb.sv
// Single-cycle datapath: logic, LUI, add/sub with flags and signed compares.
module alu_mc_comb
    import alu_mc_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             ovf,
    output logic             err
);

    logic [WIDTH:0] sum_ext;
    logic [WIDTH:0] dif_ext;
    logic           lt;
    logic           gt;

    assign sum_ext = {1'b0, a} + {1'b0, b};
    assign dif_ext = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
    // Native signed compare, so no dependence on the (possibly overflowed) difference
    assign lt = $signed(a) < $signed(b);
    assign gt = $signed(a) > $signed(b);

    always_comb begin
        result = '0;
        carry  = 1'b0;
        ovf    = 1'b0;
        err    = 1'b0;
        case (op)
            OP_OR:     result = a | b;
            OP_AND:    result = a & b;
            OP_XOR:    result = a ^ b;
            OP_NOR:    result = ~(a | b);
            OP_NOT_A:  result = ~a;
            OP_PASS_A: result = a;
            OP_PASS_B: result = b;
            OP_LUI:    result = {b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
            OP_ADD: begin
                result = sum_ext[WIDTH-1:0];
                carry  = sum_ext[WIDTH];
                ovf    = (a[WIDTH-1] == b[WIDTH-1]) && (sum_ext[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                result = dif_ext[WIDTH-1:0];
                carry  = dif_ext[WIDTH];
                ovf    = (a[WIDTH-1] != b[WIDTH-1]) && (dif_ext[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SLT:    result = {{(WIDTH-1){1'b0}}, lt};
            OP_SGT:    result = {{(WIDTH-1){1'b0}}, gt};
            OP_RSVD:   err = 1'b1;
            default:   ;
        endcase
    end

endmodule

// File: rtl/alu_mc.sv
// Registered multi-cycle ALU with valid/ready handshakes; shifts take one cycle per bit.
module alu_mc
    import alu_mc_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry,
    output logic             ovf,
    output logic             err
);

    state_t           state_reg;
    logic [3:0]       op_reg;
    logic [WIDTH-1:0] shift_reg;
    logic [SHW-1:0]   cnt_reg;
    logic [WIDTH-1:0] result_reg;
    logic             zero_reg;
    logic             carry_reg;
    logic             ovf_reg;
    logic             err_reg;
    logic             out_valid_reg;

    logic [WIDTH-1:0] comb_result;
    logic             comb_carry;
    logic             comb_ovf;
    logic             comb_err;
    logic [WIDTH-1:0] shift_next;
    logic             shift_out;
    logic [SHW-1:0]   shamt;
    logic             accept;

    alu_mc_comb #(.WIDTH(WIDTH)) u_comb (
        .op     (op),
        .a      (a),
        .b      (b),
        .result (comb_result),
        .carry  (comb_carry),
        .ovf    (comb_ovf),
        .err    (comb_err)
    );

    // Gated by rst_n so the block never advertises readiness while held in reset
    assign in_ready = rst_n & ((state_reg == ST_IDLE) | ((state_reg == ST_DONE) & out_ready));
    assign accept   = in_valid & in_ready;
    assign shamt    = b[SHW-1:0];

    always_comb begin
        shift_next = shift_reg;
        shift_out  = 1'b0;
        case (op_reg)
            OP_SLL: begin
                shift_next = {shift_reg[WIDTH-2:0], 1'b0};
                shift_out  = shift_reg[WIDTH-1];
            end
            OP_SRL: begin
                shift_next = {1'b0, shift_reg[WIDTH-1:1]};
                shift_out  = shift_reg[0];
            end
            OP_SRA: begin
                shift_next = {shift_reg[WIDTH-1], shift_reg[WIDTH-1:1]};
                shift_out  = shift_reg[0];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            op_reg        <= OP_OR;
            shift_reg     <= '0;
            cnt_reg       <= '0;
            result_reg    <= '0;
            zero_reg      <= 1'b0;
            carry_reg     <= 1'b0;
            ovf_reg       <= 1'b0;
            err_reg       <= 1'b0;
            out_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_SHIFT: begin
                    shift_reg <= shift_next;
                    cnt_reg   <= cnt_reg - 1'b1;
                    if (cnt_reg == {{(SHW-1){1'b0}}, 1'b1}) begin
                        result_reg    <= shift_next;
                        zero_reg      <= (shift_next == '0);
                        carry_reg     <= shift_out;
                        out_valid_reg <= 1'b1;
                        state_reg     <= ST_DONE;
                    end
                end
                default: begin
                    if (accept) begin
                        op_reg <= op;
                        if (is_shift(op) && (shamt != '0)) begin
                            shift_reg     <= a;
                            cnt_reg       <= shamt;
                            ovf_reg       <= 1'b0;
                            err_reg       <= 1'b0;
                            out_valid_reg <= 1'b0;
                            state_reg     <= ST_SHIFT;
                        end else if (is_shift(op)) begin
                            result_reg    <= a;
                            zero_reg      <= (a == '0);
                            carry_reg     <= 1'b0;
                            ovf_reg       <= 1'b0;
                            err_reg       <= 1'b0;
                            out_valid_reg <= 1'b1;
                            state_reg     <= ST_DONE;
                        end else begin
                            result_reg    <= comb_result;
                            zero_reg      <= (comb_result == '0);
                            carry_reg     <= comb_carry;
                            ovf_reg       <= comb_ovf;
                            err_reg       <= comb_err;
                            out_valid_reg <= 1'b1;
                            state_reg     <= ST_DONE;
                        end
                    end else if ((state_reg == ST_DONE) && out_ready) begin
                        out_valid_reg <= 1'b0;
                        state_reg     <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign out_valid = out_valid_reg;
    assign result    = result_reg;
    assign zero      = zero_reg;
    assign carry     = carry_reg;
    assign ovf       = ovf_reg;
    assign err       = err_reg;

endmodule

// File: tb/tb_alu_mc.sv
// Directed-vector bench for alu_mc (WIDTH=32) with hand-computed expectations.
module tb_alu_mc;
    import alu_mc_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        carry;
    logic        ovf;
    logic        err;

    int vectors;
    int miscompares;

    alu_mc #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .carry     (carry),
        .ovf       (ovf),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Present one request for a single edge; readiness is checked just before the edge.
    task automatic drive(input logic [3:0] xop, input logic [31:0] xa, input logic [31:0] xb);
        @(negedge clk);
        in_valid = 1'b1;
        op = xop;
        a  = xa;
        b  = xb;
        check("in_ready_before_issue", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Issue an op, measure extra cycles until out_valid, then check all outputs.
    task automatic run_op(input string tag, input logic [3:0] xop, input logic [31:0] xa,
                          input logic [31:0] xb, input logic [31:0] er, input logic ec,
                          input logic ev, input int elat);
        int lat;
        int rdy_seen;
        drive(xop, xa, xb);
        lat = 0;
        rdy_seen = 0;
        while (!out_valid && lat < 64) begin
            if (in_ready) rdy_seen++;
            @(posedge clk);
            #1;
            lat++;
        end
        $display("op %0d a=0x%08h b=0x%08h -> result=0x%08h c=%0b v=%0b z=%0b e=%0b lat=%0d (%s)",
                 xop, xa, xb, result, carry, ovf, zero, err, lat, tag);
        check({tag, ".latency"}, lat, elat);
        check({tag, ".ready_during_shift"}, rdy_seen, 0);
        check({tag, ".out_valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, ".result"}, result, er);
        check({tag, ".carry"}, {31'd0, carry}, {31'd0, ec});
        check({tag, ".ovf"}, {31'd0, ovf}, {31'd0, ev});
        check({tag, ".zero"}, {31'd0, zero}, {31'd0, (er == 32'd0)});
        check({tag, ".err"}, {31'd0, err}, {31'd0, (xop == OP_RSVD)});
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op = 4'd0;
        a  = '0;
        b  = '0;

        #12;
        check("rst.in_ready", {31'd0, in_ready}, 32'd0);
        check("rst.out_valid", {31'd0, out_valid}, 32'd0);
        check("rst.result", result, 32'd0);
        check("rst.flags", {28'd0, zero, carry, ovf, err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst.in_ready", {31'd0, in_ready}, 32'd1);

        out_ready = 1'b1;
        run_op("add_wrap", OP_ADD, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1'b0, 0);
        run_op("sub_ovf", OP_SUB, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 1'b1, 1'b1, 0);
        run_op("slt_min", OP_SLT, 32'h8000_0000, 32'd1, 32'd1, 1'b0, 1'b0, 0);
        run_op("sgt_min", OP_SGT, 32'h8000_0000, 32'd1, 32'd0, 1'b0, 1'b0, 0);
        run_op("sgt_max", OP_SGT, 32'h7FFF_FFFF, 32'h8000_0000, 32'd1, 1'b0, 1'b0, 0);
        run_op("slt_neg", OP_SLT, 32'hFFFF_FFFF, 32'd0, 32'd1, 1'b0, 1'b0, 0);
        run_op("add_ovf", OP_ADD, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b0, 1'b1, 0);
        run_op("sub_borrow", OP_SUB, 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b0, 1'b0, 0);
        run_op("sub_equal", OP_SUB, 32'd7, 32'd7, 32'd0, 1'b1, 1'b0, 0);
        run_op("or", OP_OR, 32'hF0F0_1234, 32'h0FF0_FF00, 32'hFFF0_FF34, 1'b0, 1'b0, 0);
        run_op("and", OP_AND, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 1'b0, 1'b0, 0);
        run_op("xor", OP_XOR, 32'hF0F0_1234, 32'h0FF0_FF00, 32'hFF00_ED34, 1'b0, 1'b0, 0);
        run_op("nor", OP_NOR, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h000F_00CB, 1'b0, 1'b0, 0);
        run_op("not_a", OP_NOT_A, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h0F0F_EDCB, 1'b0, 1'b0, 0);
        run_op("pass_a", OP_PASS_A, 32'hF0F0_1234, 32'h0FF0_FF00, 32'hF0F0_1234, 1'b0, 1'b0, 0);
        run_op("pass_b", OP_PASS_B, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h0FF0_FF00, 1'b0, 1'b0, 0);

        // Shifts: latency counted in edges after acceptance
        run_op("sra4", OP_SRA, 32'h8000_0010, 32'd4, 32'hF800_0001, 1'b0, 1'b0, 4);
        run_op("sll1", OP_SLL, 32'h8000_0001, 32'd1, 32'h0000_0002, 1'b1, 1'b0, 1);
        run_op("srl0", OP_SRL, 32'h0000_1234, 32'h0000_0020, 32'h0000_1234, 1'b0, 1'b0, 0);
        run_op("srl31", OP_SRL, 32'h8000_0000, 32'd31, 32'h0000_0001, 1'b0, 1'b0, 31);
        run_op("srl_out", OP_SRL, 32'h0000_0003, 32'd1, 32'h0000_0001, 1'b1, 1'b0, 1);

        // Back-to-back: LUI then OR on consecutive edges
        @(negedge clk);
        in_valid = 1'b1;
        op = OP_LUI;
        a  = 32'hDEAD_BEEF;
        b  = 32'h0000_1234;
        @(posedge clk);
        #1;
        check("b2b.lui_valid", {31'd0, out_valid}, 32'd1);
        check("b2b.lui_result", result, 32'h1234_0000);
        check("b2b.ready_in_done", {31'd0, in_ready}, 32'd1);
        op = OP_OR;
        a  = 32'h0000_00F0;
        b  = 32'h0000_000F;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        $display("b2b LUI/OR -> result=0x%08h out_valid=%0b", result, out_valid);
        check("b2b.or_valid", {31'd0, out_valid}, 32'd1);
        check("b2b.or_result", result, 32'h0000_00FF);
        @(posedge clk);
        #1;
        check("b2b.idle_valid", {31'd0, out_valid}, 32'd0);

        // Backpressure: result must hold while out_ready is low
        out_ready = 1'b0;
        drive(OP_XOR, 32'h5A5A_5A5A, 32'h5A5A_5A5A);
        a = 32'h1111_1111;
        for (int i = 0; i < 3; i++) begin
            check("bp.out_valid", {31'd0, out_valid}, 32'd1);
            check("bp.result", result, 32'd0);
            check("bp.zero", {31'd0, zero}, 32'd1);
            check("bp.in_ready", {31'd0, in_ready}, 32'd0);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        #1;
        check("bp.release_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        $display("backpressure XOR released -> out_valid=%0b", out_valid);
        check("bp.drained", {31'd0, out_valid}, 32'd0);

        // Reset in the middle of a long shift
        drive(OP_SLL, 32'h0000_0001, 32'd20);
        repeat (3) @(posedge clk);
        #2;
        check("shift.busy_ready", {31'd0, in_ready}, 32'd0);
        rst_n = 1'b0;
        #1;
        $display("async reset during SLL -> out_valid=%0b zero=%0b", out_valid, zero);
        check("abort.in_ready", {31'd0, in_ready}, 32'd0);
        check("abort.out_valid", {31'd0, out_valid}, 32'd0);
        check("abort.result", result, 32'd0);
        check("abort.flags", {28'd0, zero, carry, ovf, err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (25) @(posedge clk);
        #1;
        check("abort.no_stale_valid", {31'd0, out_valid}, 32'd0);
        check("abort.ready_again", {31'd0, in_ready}, 32'd1);

        run_op("rsvd", OP_RSVD, 32'h0000_0005, 32'h0000_0006, 32'd0, 1'b0, 1'b0, 0);
        run_op("err_clear", OP_OR, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule
